// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one data-bus transaction per load/store, with alignment,
// size-code and timeout checking, and extended load data returned to writeback.
module rv32i_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic [4:0]  LOGISIM_CLOCK_TREE_0,
    input  logic        rst_n,
    input  logic        op_load,
    input  logic        op_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic clk;
    logic unused_clk_bits;
    assign clk             = LOGISIM_CLOCK_TREE_0[4];
    assign unused_clk_bits = ^LOGISIM_CLOCK_TREE_0[3:0];

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        is_load;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        request;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] shifted;
    logic [31:0] load_value;

    always_comb begin
        request    = op_load | op_store;
        illegal    = (op_load & op_store) | (funct3 == 3'b011) |
                     (funct3[2:1] == 2'b11) | (op_store & funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << addr[1:0];
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
        endcase
    end

    // Load lane is selected by the registered byte offset, not the live address.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_value = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_value = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_value = {24'd0, shifted[7:0]};
            3'b101:  load_value = {16'd0, shifted[15:0]};
            default: load_value = shifted;
        endcase
    end

    assign stall = (state == REQ) | ((state == IDLE) & request);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            is_load     <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            err_code    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
        end else begin
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        f3_q    <= funct3;
                        off_q   <= addr[1:0];
                        is_load <= op_load;
                        if (illegal) begin
                            state    <= FAULT;
                            err      <= 1'b1;
                            err_code <= 2'b11;
                        end else if (misaligned) begin
                            state    <= FAULT;
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end else begin
                            state     <= REQ;
                            wait_cnt  <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= op_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        if (is_load) begin
                            rdata       <= load_value;
                            rdata_valid <= 1'b1;
                        end
                    end else if (wait_cnt + 8'd1 == TIMEOUT_LIMIT) begin
                        state    <= FAULT;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_be   <= '0;
                        err      <= 1'b1;
                        err_code <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed self-checking bench for rv32i_lsu (built with TIMEOUT_CYCLES = 4).
module tb_rv32i_lsu;
    logic        clk = 1'b0;
    logic [4:0]  clk_tree;
    logic        rst_n;
    logic        op_load, op_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid, err;
    logic [1:0]  err_code;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;

    int          o_req_cycles, o_end, o_valid, o_err;
    logic        o_stall0, o_stall_req, o_stall_end, o_unstable, o_we;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [1:0]  o_code;

    always #5 clk = ~clk;
    assign clk_tree = {clk, 4'b0000};

    rv32i_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .LOGISIM_CLOCK_TREE_0(clk_tree),
        .rst_n(rst_n),
        .op_load(op_load),
        .op_store(op_store),
        .funct3(funct3),
        .addr(addr),
        .wdata(wdata),
        .stall(stall),
        .rdata(rdata),
        .rdata_valid(rdata_valid),
        .err(err),
        .err_code(err_code),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction; ack is raised in REQ cycle index ack_wait (-1: never).
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_wait);
        step();
        op_load = ld; op_store = st; funct3 = f3; addr = a; wdata = wd;
        mem_rdata = rd; mem_ack = 1'b0;
        @(negedge clk);
        o_stall0 = stall;
        o_stall_req = 1'b1;
        o_req_cycles = 0; o_valid = 0; o_err = 0; o_unstable = 1'b0; o_end = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            mem_ack = (c - 1 == ack_wait);
            @(negedge clk);
            if (rdata_valid) o_valid++;
            if (err) o_err++;
            if (mem_req) begin
                o_stall_req = o_stall_req & stall;
                if (o_req_cycles == 0) begin
                    o_we = mem_we; o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata;
                end else if ({mem_we, mem_be, mem_addr, mem_wdata} !== {o_we, o_be, o_addr, o_wdata}) begin
                    o_unstable = 1'b1;
                end
                o_req_cycles++;
            end else begin
                o_end = c; o_stall_end = stall; o_rdata = rdata; o_code = err_code;
                break;
            end
        end
        step();
        op_load = 1'b0; op_store = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_load = 0; op_store = 0; funct3 = 0; addr = 0; wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({mem_req, mem_we, mem_be, rdata_valid, err, err_code, stall} !== 10'd0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0", {mem_req, mem_we, mem_be, rdata_valid, err, err_code, stall});
        end
        total++;
        if ({rdata, mem_addr, mem_wdata} !== 96'd0) begin
            bad++; $display("FAIL reset_data: got %h %h %h want 0", rdata, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        total++;
        if ({o_stall0, o_stall_req, o_stall_end} !== 3'b110) begin
            bad++; $display("FAIL lw_stall: got %b want 110", {o_stall0, o_stall_req, o_stall_end});
        end
        total++;
        if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0) begin
            bad++; $display("FAIL lw_bus: got addr=%h be=%b we=%b want 100 1111 0", o_addr, o_be, o_we);
        end
        total++;
        if (o_end !== 2 || o_req_cycles !== 1 || o_valid !== 1) begin
            bad++; $display("FAIL lw_timing: got end=%0d req=%0d valid=%0d want 2 1 1", o_end, o_req_cycles, o_valid);
        end
        total++;
        if (o_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL lw_rdata: got %h want deadbeef", o_rdata);
        end
        total++;
        if (rdata_valid !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL lw_after: got valid=%b rdata=%h want 0 deadbeef", rdata_valid, rdata);
        end
    endtask

    task automatic test_sub_word_loads();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] as  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [3:0]  bes [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
        logic [31:0] exs [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        for (int i = 0; i < 4; i++) begin
            run_access(1'b1, 1'b0, f3s[i], as[i], 32'h0, 32'h80FF1234, 0);
            total++;
            if (o_be !== bes[i] || o_addr !== 32'h100) begin
                bad++; $display("FAIL subload_bus[%0d]: got be=%b addr=%h want %b 100", i, o_be, o_addr, bes[i]);
            end
            total++;
            if (o_rdata !== exs[i] || o_valid !== 1) begin
                bad++; $display("FAIL subload_rdata[%0d]: got %h valid=%0d want %h 1", i, o_rdata, o_valid, exs[i]);
            end
        end
    endtask

    task automatic test_stores();
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h55555555, 3);
        total++;
        if (o_we !== 1'b1 || o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD || o_addr !== 32'h200) begin
            bad++; $display("FAIL sh_bus: got we=%b be=%b wdata=%h addr=%h want 1 1100 abcdabcd 200", o_we, o_be, o_wdata, o_addr);
        end
        total++;
        if (o_req_cycles !== 4 || o_unstable !== 1'b0 || o_end !== 5) begin
            bad++; $display("FAIL sh_hold: got req=%0d unstable=%b end=%0d want 4 0 5", o_req_cycles, o_unstable, o_end);
        end
        total++;
        if (o_valid !== 0 || o_err !== 0 || o_rdata !== 32'h000080FF) begin
            bad++; $display("FAIL sh_rdata: got valid=%0d err=%0d rdata=%h want 0 0 000080ff", o_valid, o_err, o_rdata);
        end
        run_access(1'b0, 1'b1, 3'b000, 32'h001, 32'hCAFE005A, 32'h0, 1);
        total++;
        if (o_be !== 4'b0010 || o_wdata !== 32'h5A5A5A5A || o_end !== 3) begin
            bad++; $display("FAIL sb_bus: got be=%b wdata=%h end=%0d want 0010 5a5a5a5a 3", o_be, o_wdata, o_end);
        end
    endtask

    task automatic test_faults();
        logic        lds [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        sts [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [5] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b011};
        logic [31:0] as  [5] = '{32'h101, 32'h100, 32'h103, 32'h100, 32'h100};
        logic [1:0]  cds [5] = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b11};
        for (int i = 0; i < 5; i++) begin
            run_access(lds[i], sts[i], f3s[i], as[i], 32'h0, 32'h0, 0);
            total++;
            if (o_req_cycles !== 0 || o_end !== 1 || o_err !== 1 || o_code !== cds[i]) begin
                bad++; $display("FAIL fault[%0d]: got req=%0d end=%0d err=%0d code=%b want 0 1 1 %b", i, o_req_cycles, o_end, o_err, o_code, cds[i]);
            end
            total++;
            if (o_stall0 !== 1'b1 || o_stall_end !== 1'b0 || err !== 1'b0 || err_code !== cds[i]) begin
                bad++; $display("FAIL fault_after[%0d]: got stall0=%b stall_end=%b err=%b code=%b want 1 0 0 %b", i, o_stall0, o_stall_end, err, err_code, cds[i]);
            end
        end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, -1);
        total++;
        if (o_req_cycles !== 4 || o_end !== 5) begin
            bad++; $display("FAIL timeout_len: got req=%0d end=%0d want 4 5", o_req_cycles, o_end);
        end
        total++;
        if (o_err !== 1 || o_code !== 2'b10 || o_stall_end !== 1'b0 || o_valid !== 0) begin
            bad++; $display("FAIL timeout_err: got err=%0d code=%b stall=%b valid=%0d want 1 10 0 0", o_err, o_code, o_stall_end, o_valid);
        end
    endtask

    task automatic test_back_to_back();
        step();
        op_store = 1'b1; funct3 = 3'b100; addr = 32'h10; mem_ack = 1'b0;
        step();
        total++;
        if (err !== 1'b1 || err_code !== 2'b11) begin
            bad++; $display("FAIL b2b_fault: got err=%b code=%b want 1 11", err, err_code);
        end
        op_store = 1'b0; op_load = 1'b1; funct3 = 3'b010; addr = 32'h40; mem_rdata = 32'h0A0B0C0D;
        step();
        total++;
        if (stall !== 1'b1 || mem_req !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL b2b_accept: got stall=%b req=%b err=%b want 1 0 0", stall, mem_req, err);
        end
        step();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            bad++; $display("FAIL b2b_req: got req=%b addr=%h want 1 40", mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; op_load = 1'b0;
        total++;
        if (rdata_valid !== 1'b1 || rdata !== 32'h0A0B0C0D) begin
            bad++; $display("FAIL b2b_done: got valid=%b rdata=%h want 1 0a0b0c0d", rdata_valid, rdata);
        end
    endtask

    task automatic test_reset_mid();
        step();
        op_load = 1'b1; funct3 = 3'b010; addr = 32'h500; mem_ack = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre: got req=%b want 1", mem_req);
        end
        #1 rst_n = 1'b0; op_load = 1'b0;
        #1;
        total++;
        if ({mem_req, mem_be, rdata_valid, err} !== 7'd0 || {rdata, mem_addr} !== 64'd0) begin
            bad++; $display("FAIL rstmid_drop: got req=%b be=%b rdata=%h addr=%h want 0", mem_req, mem_be, rdata, mem_addr);
        end
        step();
        total++;
        if (rdata_valid !== 1'b0 || err !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL rstmid_nopulse: got valid=%b err=%b stall=%b want 0 0 0", rdata_valid, err, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 1);
        total++;
        if (o_end !== 3 || o_req_cycles !== 2 || o_valid !== 1 || o_rdata !== 32'h0BADF00D || o_addr !== 32'h104) begin
            bad++; $display("FAIL rstmid_next: got end=%0d req=%0d valid=%0d rdata=%h addr=%h want 3 2 1 0badf00d 104", o_end, o_req_cycles, o_valid, o_rdata, o_addr);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub_word_loads();
        test_stores();
        test_faults();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
